// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: any depth >= 2, programmable almost-full /
// almost-empty thresholds, occupancy count, registered or first-word-fall-through read.
// Ports: clk/rst (sync, active high); data_in/wr_en write side; rd_en/data_out/rd_valid
// read side; wr_ack/overflow/underflow one-cycle status pulses; full/empty/almostfull/
// almostempty/count occupancy. Latency: write visible 1 cycle later; no backpressure
// beyond full/empty rejection (rejected requests are reported, never stalled).
module sync_fifo_param #(
  parameter int FIFO_WIDTH      = 16,
  parameter int FIFO_DEPTH      = 8,
  parameter int ALMOST_FULL_TH  = FIFO_DEPTH - 1,
  parameter int ALMOST_EMPTY_TH = 1,
  parameter int FWFT            = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [FIFO_WIDTH-1:0]             data_in,
  input  logic                              wr_en,
  input  logic                              rd_en,
  output logic [FIFO_WIDTH-1:0]             data_out,
  output logic                              rd_valid,
  output logic                              wr_ack,
  output logic                              overflow,
  output logic                              underflow,
  output logic                              full,
  output logic                              empty,
  output logic                              almostfull,
  output logic                              almostempty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [PW-1:0] LP_LAST  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] LP_DEPTH = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LP_AF    = CW'(ALMOST_FULL_TH);
  localparam logic [CW-1:0] LP_AE    = CW'(ALMOST_EMPTY_TH);

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [FIFO_WIDTH-1:0] r_dout;
  logic                  r_rd_valid;
  logic                  r_wr_ack;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [FIFO_WIDTH-1:0] w_head;

  // Flags come only from the registered count, so no request input reaches an output.
  assign w_full   = (r_count == LP_DEPTH);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = wr_en && !w_full && !rst;
  assign w_rd_acc = rd_en && !w_empty && !rst;
  assign w_head   = r_mem[r_rd_ptr];

  // Storage has no reset; emptiness is tracked purely by pointers and count.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_dout      <= '0;
      r_rd_valid  <= 1'b0;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
      if (w_wr_acc) begin
        r_wr_ptr <= (r_wr_ptr == LP_LAST) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= (r_rd_ptr == LP_LAST) ? '0 : r_rd_ptr + PW'(1);
      end

      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      r_wr_ack    <= w_wr_acc;
      r_overflow  <= wr_en && w_full;
      r_underflow <= rd_en && w_empty;

      if (FWFT != 0) begin
        // Shadow of the word currently presented, so data_out holds it once empty.
        if (!w_empty) begin
          r_dout <= w_head;
        end
        r_rd_valid <= 1'b0;
      end else begin
        if (w_rd_acc) begin
          r_dout <= w_head;
        end
        r_rd_valid <= w_rd_acc;
      end
    end
  end

  assign data_out    = ((FWFT != 0) && !w_empty) ? w_head : r_dout;
  assign rd_valid    = (FWFT != 0) ? !w_empty : r_rd_valid;
  assign wr_ack      = r_wr_ack;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;
  assign full        = w_full;
  assign empty       = w_empty;
  assign almostfull  = (r_count >= LP_AF);
  assign almostempty = (r_count <= LP_AE);
  assign count       = r_count;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: default geometry, DEPTH=5 wrap, and FWFT mode.
// All three instances share clock and reset; each has its own request signals.
// Expected values are hand-derived constants and simple loop expressions.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- instance A: default 16x8, AF=7, AE=1, registered read
  logic [15:0] a_din = '0;
  logic        a_wr = 1'b0, a_rd = 1'b0;
  logic [15:0] a_dout;
  logic        a_rdv, a_ack, a_ovf, a_udf, a_full, a_empty, a_af, a_ae;
  logic [3:0]  a_cnt;

  sync_fifo_param u_dut_a (
    .clk(clk), .rst(rst), .data_in(a_din), .wr_en(a_wr), .rd_en(a_rd),
    .data_out(a_dout), .rd_valid(a_rdv), .wr_ack(a_ack), .overflow(a_ovf),
    .underflow(a_udf), .full(a_full), .empty(a_empty), .almostfull(a_af),
    .almostempty(a_ae), .count(a_cnt)
  );

  // ---------------- instance B: DEPTH=5 (non power of two)
  logic [15:0] b_din = '0;
  logic        b_wr = 1'b0, b_rd = 1'b0;
  logic [15:0] b_dout;
  logic        b_rdv, b_ack, b_ovf, b_udf, b_full, b_empty, b_af, b_ae;
  logic [2:0]  b_cnt;

  sync_fifo_param #(.FIFO_DEPTH(5)) u_dut_b (
    .clk(clk), .rst(rst), .data_in(b_din), .wr_en(b_wr), .rd_en(b_rd),
    .data_out(b_dout), .rd_valid(b_rdv), .wr_ack(b_ack), .overflow(b_ovf),
    .underflow(b_udf), .full(b_full), .empty(b_empty), .almostfull(b_af),
    .almostempty(b_ae), .count(b_cnt)
  );

  // ---------------- instance C: FWFT
  logic [15:0] c_din = '0;
  logic        c_wr = 1'b0, c_rd = 1'b0;
  logic [15:0] c_dout;
  logic        c_rdv, c_ack, c_ovf, c_udf, c_full, c_empty, c_af, c_ae;
  logic [3:0]  c_cnt;

  sync_fifo_param #(.FWFT(1)) u_dut_c (
    .clk(clk), .rst(rst), .data_in(c_din), .wr_en(c_wr), .rd_en(c_rd),
    .data_out(c_dout), .rd_valid(c_rdv), .wr_ack(c_ack), .overflow(c_ovf),
    .underflow(c_udf), .full(c_full), .empty(c_empty), .almostfull(c_af),
    .almostempty(c_ae), .count(c_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle; outputs are sampled 1 time unit after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_push(input logic [15:0] d);
    a_din = d; a_wr = 1'b1; step(); a_wr = 1'b0;
  endtask

  task automatic a_pop_expect(input string tag, input logic [15:0] d);
    a_rd = 1'b1; step(); a_rd = 1'b0;
    check(tag, 32'(a_dout), 32'(d));
    check({tag, "_rdv"}, 32'(a_rdv), 32'd1);
  endtask

  task automatic b_push(input logic [15:0] d);
    b_din = d; b_wr = 1'b1; step(); b_wr = 1'b0;
  endtask

  task automatic b_pop_expect(input string tag, input logic [15:0] d);
    b_rd = 1'b1; step(); b_rd = 1'b0;
    check(tag, 32'(b_dout), 32'(d));
  endtask

  initial begin
    // ---------------- reset state
    rst = 1'b1; step(); step(); rst = 1'b0;
    check("rst_count", 32'(a_cnt), 32'd0);
    check("rst_empty", 32'(a_empty), 32'd1);
    check("rst_ae", 32'(a_ae), 32'd1);
    check("rst_full", 32'(a_full), 32'd0);
    check("rst_af", 32'(a_af), 32'd0);
    check("rst_dout", 32'(a_dout), 32'd0);
    check("rst_pulses", 32'({a_rdv, a_ack, a_ovf, a_udf}), 32'd0);
    check("rst_b_empty", 32'(b_empty), 32'd1);
    check("rst_c_rdv", 32'(c_rdv), 32'd0);
    check("rst_c_dout", 32'(c_dout), 32'd0);

    // ---------------- fill 1..8
    for (int i = 1; i <= 8; i++) begin
      a_push(16'(i));
      check("fill_ack", 32'(a_ack), 32'd1);
      check("fill_count", 32'(a_cnt), 32'(i));
      check("fill_af", 32'(a_af), 32'(i >= 7));
      check("fill_full", 32'(a_full), 32'(i == 8));
      check("fill_ae", 32'(a_ae), 32'(i <= 1));
    end

    // ---------------- overflow
    a_push(16'hDEAD);
    check("ovf_pulse", 32'(a_ovf), 32'd1);
    check("ovf_ack", 32'(a_ack), 32'd0);
    check("ovf_count", 32'(a_cnt), 32'd8);
    step();
    check("ovf_clear", 32'(a_ovf), 32'd0);

    for (int i = 1; i <= 8; i++) begin
      a_pop_expect("drain_data", 16'(i));
      check("drain_count", 32'(a_cnt), 32'(8 - i));
    end
    check("drain_empty", 32'(a_empty), 32'd1);

    // ---------------- underflow
    a_rd = 1'b1; step(); a_rd = 1'b0;
    check("udf_pulse", 32'(a_udf), 32'd1);
    check("udf_dout", 32'(a_dout), 32'h0008);
    check("udf_rdv", 32'(a_rdv), 32'd0);
    check("udf_count", 32'(a_cnt), 32'd0);
    step();
    check("udf_clear", 32'(a_udf), 32'd0);

    // ---------------- simultaneous at count=4
    for (int i = 0; i < 4; i++) a_push(16'h0011 + 16'(i));
    for (int i = 0; i < 3; i++) begin
      a_din = 16'h0015 + 16'(i); a_wr = 1'b1; a_rd = 1'b1; step();
      check("rw_data", 32'(a_dout), 32'h0011 + 32'(i));
      check("rw_count", 32'(a_cnt), 32'd4);
      check("rw_ack", 32'(a_ack), 32'd1);
    end
    a_wr = 1'b0; a_rd = 1'b0;
    for (int i = 0; i < 4; i++) a_pop_expect("rw_order", 16'h0014 + 16'(i));
    check("rw_empty", 32'(a_empty), 32'd1);

    // ---------------- empty + both
    a_din = 16'h0020; a_wr = 1'b1; a_rd = 1'b1; step(); a_wr = 1'b0; a_rd = 1'b0;
    check("eb_udf", 32'(a_udf), 32'd1);
    check("eb_ack", 32'(a_ack), 32'd1);
    check("eb_rdv", 32'(a_rdv), 32'd0);
    check("eb_count", 32'(a_cnt), 32'd1);
    a_pop_expect("eb_data", 16'h0020);

    // ---------------- full + both
    for (int i = 0; i < 8; i++) a_push(16'h0031 + 16'(i));
    check("fb_full", 32'(a_full), 32'd1);
    a_din = 16'h0099; a_wr = 1'b1; a_rd = 1'b1; step(); a_wr = 1'b0; a_rd = 1'b0;
    check("fb_ovf", 32'(a_ovf), 32'd1);
    check("fb_ack", 32'(a_ack), 32'd0);
    check("fb_data", 32'(a_dout), 32'h0031);
    check("fb_count", 32'(a_cnt), 32'd7);
    for (int i = 1; i < 8; i++) a_pop_expect("fb_rest", 16'h0031 + 16'(i));
    check("fb_empty", 32'(a_empty), 32'd1);

    // ---------------- DEPTH=5 wrap
    for (int i = 0; i < 5; i++) b_push(16'h000A + 16'(i));
    check("wrap_full", 32'(b_full), 32'd1);
    check("wrap_count5", 32'(b_cnt), 32'd5);
    for (int i = 0; i < 3; i++) b_pop_expect("wrap_first", 16'h000A + 16'(i));
    for (int i = 0; i < 3; i++) b_push(16'h000F + 16'(i));
    check("wrap_full2", 32'(b_full), 32'd1);
    for (int i = 0; i < 5; i++) b_pop_expect("wrap_second", 16'h000D + 16'(i));
    check("wrap_empty", 32'(b_empty), 32'd1);

    // ---------------- FWFT
    c_din = 16'hA5A5; c_wr = 1'b1; step(); c_wr = 1'b0;
    check("fwft_dout", 32'(c_dout), 32'hA5A5);
    check("fwft_rdv", 32'(c_rdv), 32'd1);
    check("fwft_nempty", 32'(c_empty), 32'd0);
    c_rd = 1'b1; step(); c_rd = 1'b0;
    check("fwft_empty", 32'(c_empty), 32'd1);
    check("fwft_rdv0", 32'(c_rdv), 32'd0);
    check("fwft_hold", 32'(c_dout), 32'hA5A5);
    c_din = 16'h1111; c_wr = 1'b1; step();
    c_din = 16'h2222; step(); c_wr = 1'b0;
    check("fwft_head1", 32'(c_dout), 32'h1111);
    c_rd = 1'b1; step();
    check("fwft_head2", 32'(c_dout), 32'h2222);
    step(); c_rd = 1'b0;
    check("fwft_hold2", 32'(c_dout), 32'h2222);
    check("fwft_empty2", 32'(c_empty), 32'd1);

    // ---------------- reset mid-operation
    for (int i = 0; i < 5; i++) a_push(16'h0041 + 16'(i));
    check("mid_count5", 32'(a_cnt), 32'd5);
    a_pop_expect("mid_pre", 16'h0041);
    a_push(16'h0046);
    rst = 1'b1; a_din = 16'h0077; a_wr = 1'b1; step(); rst = 1'b0; a_wr = 1'b0;
    check("mid_count", 32'(a_cnt), 32'd0);
    check("mid_empty", 32'(a_empty), 32'd1);
    check("mid_pulses", 32'({a_rdv, a_ack, a_ovf, a_udf}), 32'd0);
    check("mid_dout", 32'(a_dout), 32'd0);
    a_rd = 1'b1; step(); a_rd = 1'b0;
    check("mid_udf", 32'(a_udf), 32'd1);
    check("mid_count_after", 32'(a_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
